// File: rtl/tt_um_heart_rate_monitor.sv
// Multi-channel beat-interval monitor: measures beat-to-beat period in prescaled ticks
// and raises sticky tachycardia / bradycardia / asystole alarms.
//
// state  | meaning
// IDLE   | no beat seen since reset
// ARMED  | one beat seen, measuring first interval, no period yet
// TRACK  | period valid, latched on every beat
// LOST   | interval counter saturated without a beat (asystole)
module tt_um_heart_rate_monitor #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 12,
   parameter int PRESCALE = 1000,
   parameter int LOW_LIM  = 40,
   parameter int HIGH_LIM = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int PS_W = $clog2(PRESCALE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRACK = 2'd2,
      S_LOST  = 2'd3
   } state_t;

   logic [PS_W-1:0]     ps_q, ps_d;
   logic                tick;
   logic [CHANNELS-1:0] sync1_q, sync1_d;
   logic [CHANNELS-1:0] sync2_q, sync2_d;
   logic [CHANNELS-1:0] prev_q, prev_d;
   logic [CHANNELS-1:0] beat_edge;
   logic [CHANNELS-1:0] tog_q, tog_d;
   logic [CNT_W-1:0]    cnt_q    [CHANNELS];
   logic [CNT_W-1:0]    cnt_d    [CHANNELS];
   logic [CNT_W-1:0]    period_q [CHANNELS];
   logic [CNT_W-1:0]    period_d [CHANNELS];
   state_t              state_q  [CHANNELS];
   state_t              state_d  [CHANNELS];
   logic                tachy_q, tachy_d;
   logic                brady_q, brady_d;
   logic                asys_q, asys_d;
   logic                set_tachy, set_brady, set_asys;
   logic                alarm_clr;
   logic [1:0]          sel;
   logic [CNT_W-1:0]    sel_period;
   logic                sel_valid;
   logic [15:0]         period_ext;
   logic [3:0]          tog_ext;
   logic                unused_in;

   assign unused_in = ^{uio_in, ui_in};
   assign alarm_clr = ui_in[6];
   assign sel       = ui_in[5:4];

   always_comb begin
      sync1_d   = ui_in[CHANNELS-1:0];
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      beat_edge = sync2_q & ~prev_q;

      tick = ena && (ps_q == PS_W'(PRESCALE - 1));
      ps_d = ps_q;
      if (ena) ps_d = tick ? '0 : ps_q + PS_W'(1);

      tog_d     = tog_q;
      set_tachy = 1'b0;
      set_brady = 1'b0;
      set_asys  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         cnt_d[c]    = cnt_q[c];
         period_d[c] = period_q[c];
         state_d[c]  = state_q[c];
         if (ena) begin
            if (beat_edge[c]) begin
               // An accepted beat always restarts the interval, even on a tick or at saturation.
               cnt_d[c] = '0;
               tog_d[c] = ~tog_q[c];
               if (state_q[c] == S_ARMED || state_q[c] == S_TRACK) begin
                  state_d[c]  = S_TRACK;
                  period_d[c] = cnt_q[c];
                  if (32'(cnt_q[c]) < LOW_LIM)  set_tachy = 1'b1;
                  if (32'(cnt_q[c]) > HIGH_LIM) set_brady = 1'b1;
               end else begin
                  state_d[c] = S_ARMED;
               end
            end else begin
               if (tick && cnt_q[c] != {CNT_W{1'b1}}) cnt_d[c] = cnt_q[c] + CNT_W'(1);
               if ((state_q[c] == S_ARMED || state_q[c] == S_TRACK) &&
                   cnt_q[c] == {CNT_W{1'b1}}) begin
                  state_d[c] = S_LOST;
                  set_asys   = 1'b1;
               end
            end
         end
      end

      tachy_d = tachy_q;
      brady_d = brady_q;
      asys_d  = asys_q;
      if (ena) begin
         tachy_d = set_tachy | (tachy_q & ~alarm_clr);
         brady_d = set_brady | (brady_q & ~alarm_clr);
         asys_d  = set_asys  | (asys_q  & ~alarm_clr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_q    <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         tog_q   <= '0;
         tachy_q <= 1'b0;
         brady_q <= 1'b0;
         asys_q  <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]    <= '0;
            period_q[c] <= '0;
            state_q[c]  <= S_IDLE;
         end
      end else begin
         ps_q    <= ps_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         tog_q   <= tog_d;
         tachy_q <= tachy_d;
         brady_q <= brady_d;
         asys_q  <= asys_d;
         for (int c = 0; c < CHANNELS; c++) begin
            cnt_q[c]    <= cnt_d[c];
            period_q[c] <= period_d[c];
            state_q[c]  <= state_d[c];
         end
      end
   end

   always_comb begin
      sel_period = '0;
      sel_valid  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (sel == 2'(c)) begin
            sel_period = period_q[c];
            sel_valid  = (state_q[c] == S_TRACK);
         end
      end
   end

   assign period_ext = 16'(sel_period);
   assign tog_ext    = 4'(tog_q);
   assign uo_out     = ui_in[7] ? period_ext[15:8] : period_ext[7:0];
   assign uio_out    = {tog_ext, sel_valid, asys_q, brady_q, tachy_q};
   assign uio_oe     = 8'hFF;

endmodule

// File: tb/tb_tt_um_heart_rate_monitor.sv
// Scoreboard bench for the heart-rate monitor: a cycle-indexed tick model predicts
// each latched period and the expected alarm/valid/toggle byte.
module tb_tt_um_heart_rate_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   tt_um_heart_rate_monitor #(
      .CHANNELS(2), .CNT_W(12), .PRESCALE(4), .LOW_LIM(10), .HIGH_LIM(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int p;
   } sb_t;

   sb_t sb[$];
   int  n_pass = 0;
   int  n_total = 0;
   int  acyc;

   // model: 0 idle, 1 armed, 2 track, 3 lost
   int       m_state[2];
   int       m_last[2];
   int       m_period[2];
   bit [1:0] m_tog;
   bit       m_tachy, m_brady, m_asys;

   // Index of active (ena=1) rising edges since reset; tick fires on index%4==3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acyc = 0;
      else if (ena) acyc++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int ticks_between(input int a, input int b);
      int n = 0;
      for (int i = a + 1; i < b; i++) if (i % 4 == 3) n++;
      return n;
   endfunction

   function automatic logic [7:0] exp_uio(input int s);
      logic v;
      v = (s < 2) ? (m_state[s] == 2) : 1'b0;
      return {2'b00, m_tog[1], m_tog[0], v, m_asys, m_brady, m_tachy};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      ena   = 1'b1;
      ui_in = 8'h00;
      sb.delete();
      for (int c = 0; c < 2; c++) begin
         m_state[c] = 0; m_last[c] = 0; m_period[c] = 0;
      end
      m_tog = 2'b00; m_tachy = 0; m_brady = 0; m_asys = 0;
      step(3);
      rst_n = 1'b1;
   endtask

   // Raise one beat; its latch lands on active edge acyc+2, sampled at the negedge after.
   task automatic beat(input int ch, input bit clr);
      int  l, p;
      bit  st, sb_;
      l = acyc + 2;
      st = 0; sb_ = 0;
      ui_in[ch] = 1'b1;
      m_tog[ch] = ~m_tog[ch];
      if (m_state[ch] == 1 || m_state[ch] == 2) begin
         p = ticks_between(m_last[ch], l);
         if (p > 4095) p = 4095;
         sb.push_back('{ch: ch, p: p});
         m_period[ch] = p;
         st  = (p < 10);
         sb_ = (p > 100);
         m_state[ch] = 2;
      end else begin
         m_state[ch] = 1;
      end
      m_last[ch] = l;
      if (clr) begin
         m_tachy = st; m_brady = sb_; m_asys = 0;
      end else begin
         m_tachy |= st; m_brady |= sb_;
      end
      step(2);
      if (clr) ui_in[6] = 1'b1;
      step(1);
      ui_in[ch] = 1'b0;
      ui_in[6]  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step(5);
      n_total++; if (uo_out !== 8'h00) $display("FAIL reset_uo got %h want 00", uo_out); else n_pass++;
      n_total++; if (uio_out !== 8'h00) $display("FAIL reset_uio got %h want 00", uio_out); else n_pass++;
      n_total++; if (uio_oe !== 8'hFF) $display("FAIL reset_oe got %h want FF", uio_oe); else n_pass++;
   endtask

   task automatic test_period();
      sb_t e;
      do_reset();
      ui_in[5:4] = 2'd0;
      beat(0, 0);
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL period_armed_uio got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      for (int k = 0; k < 2; k++) begin
         step(197);
         beat(0, 0);
         n_total++;
         if (sb.size() == 0) $display("FAIL period_sb_empty got 0 want 1");
         else begin
            e = sb.pop_front();
            ui_in[5:4] = 2'(e.ch); ui_in[7] = 1'b0; #1;
            if (uo_out !== 8'(e.p)) $display("FAIL period_lo got %h want %h", uo_out, 8'(e.p)); else n_pass++;
            ui_in[7] = 1'b1; #1;
            n_total++; if (uo_out !== 8'(e.p >> 8)) $display("FAIL period_hi got %h want %h", uo_out, 8'(e.p >> 8)); else n_pass++;
            ui_in[7] = 1'b0;
         end
         n_total++; if (uio_out !== exp_uio(0)) $display("FAIL period_uio got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      end
      ui_in[5:4] = 2'd2; #1;
      n_total++; if (uo_out !== 8'h00) $display("FAIL sel_oob_uo got %h want 00", uo_out); else n_pass++;
      n_total++; if (uio_out !== exp_uio(2)) $display("FAIL sel_oob_uio got %h want %h", uio_out, exp_uio(2)); else n_pass++;
      ui_in[5:4] = 2'd0;
   endtask

   task automatic test_tachy();
      sb_t e;
      do_reset();
      ui_in[5:4] = 2'd1;
      beat(1, 0);
      for (int k = 0; k < 2; k++) begin
         step(17);
         beat(1, 0);
         n_total++;
         if (sb.size() == 0) $display("FAIL tachy_sb_empty got 0 want 1");
         else begin
            e = sb.pop_front();
            ui_in[5:4] = 2'(e.ch); #1;
            if (uo_out !== 8'(e.p)) $display("FAIL tachy_period got %h want %h", uo_out, 8'(e.p)); else n_pass++;
         end
         n_total++; if (uio_out !== exp_uio(1)) $display("FAIL tachy_uio got %h want %h", uio_out, exp_uio(1)); else n_pass++;
      end
      step(4);
      ui_in[6] = 1'b1; step(1); ui_in[6] = 1'b0;
      m_tachy = 0; m_brady = 0; m_asys = 0;
      n_total++; if (uio_out !== exp_uio(1)) $display("FAIL tachy_clear got %h want %h", uio_out, exp_uio(1)); else n_pass++;
      step(10);
      beat(1, 1);
      void'(sb.pop_front());
      n_total++; if (uio_out !== exp_uio(1)) $display("FAIL tachy_clear_vs_set got %h want %h", uio_out, exp_uio(1)); else n_pass++;
   endtask

   task automatic test_asystole();
      sb_t e;
      do_reset();
      ui_in[5:4] = 2'd0;
      beat(0, 0);
      step(16400);
      if (ticks_between(m_last[0], acyc) >= 4096) begin
         m_state[0] = 3; m_asys = 1;
      end
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL asys_lost got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      beat(0, 0);
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL asys_rearm got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      step(197);
      beat(0, 0);
      n_total++;
      if (sb.size() == 0) $display("FAIL asys_sb_empty got 0 want 1");
      else begin
         e = sb.pop_front();
         #1;
         if (uo_out !== 8'(e.p)) $display("FAIL asys_period got %h want %h", uo_out, 8'(e.p)); else n_pass++;
      end
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL asys_track got %h want %h", uio_out, exp_uio(0)); else n_pass++;
   endtask

   task automatic test_tick_align_and_hold();
      sb_t        e;
      logic [7:0] uo_hold;
      do_reset();
      ui_in[5:4] = 2'd0;
      step(2);
      while ((acyc + 2) % 4 != 3) step(1);
      beat(0, 0);
      step(27);
      while ((acyc + 2) % 4 != 3) step(1);
      beat(0, 0);
      n_total++;
      if (sb.size() == 0) $display("FAIL align_sb_empty got 0 want 1");
      else begin
         e = sb.pop_front();
         #1;
         if (uo_out !== 8'(e.p)) $display("FAIL align_period got %h want %h", uo_out, 8'(e.p)); else n_pass++;
      end
      uo_hold = 8'(m_period[0]);
      ena = 1'b0;
      step(5);
      ui_in[1:0] = 2'b11; step(3); ui_in[1:0] = 2'b00;
      step(40);
      ui_in[0] = 1'b1; step(3); ui_in[0] = 1'b0;
      step(49);
      n_total++; if (uo_out !== uo_hold) $display("FAIL hold_uo got %h want %h", uo_out, uo_hold); else n_pass++;
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL hold_uio got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      ena = 1'b1;
      step(3);
      beat(0, 0);
      n_total++;
      if (sb.size() == 0) $display("FAIL resume_sb_empty got 0 want 1");
      else begin
         e = sb.pop_front();
         #1;
         if (uo_out !== 8'(e.p)) $display("FAIL resume_period got %h want %h", uo_out, 8'(e.p)); else n_pass++;
      end
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL resume_uio got %h want %h", uio_out, exp_uio(0)); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ui_in[5:4] = 2'd0;
      beat(0, 0);
      step(50);
      beat(0, 0);
      void'(sb.pop_front());
      step(20);
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (uo_out !== 8'h00) $display("FAIL midrst_uo got %h want 00", uo_out); else n_pass++;
      n_total++; if (uio_out !== 8'h00) $display("FAIL midrst_uio got %h want 00", uio_out); else n_pass++;
      n_total++; if (uio_oe !== 8'hFF) $display("FAIL midrst_oe got %h want FF", uio_oe); else n_pass++;
      do_reset();
      ui_in[5:4] = 2'd0;
      beat(0, 0);
      n_total++; if (uio_out[3] !== 1'b0) $display("FAIL midrst_valid got %b want 0", uio_out[3]); else n_pass++;
      n_total++; if (uio_out !== exp_uio(0)) $display("FAIL midrst_arm_uio got %h want %h", uio_out, exp_uio(0)); else n_pass++;
      n_total++; if (uo_out !== 8'h00) $display("FAIL midrst_arm_uo got %h want 00", uo_out); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_period();
      test_tachy();
      test_asystole();
      test_tick_align_and_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
